// File: rtl/stream_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_arb_pkg
// Purpose  : Shared FSM state type and index-width helper for stream_rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package stream_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_GRANT = 2'd2
    } arb_state_t;

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : stream_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker: first set request at or after
//            ptr, searching upward and wrapping from N-1 to 0.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import stream_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = {1'b0, ptr} + (W+1)'(k);
            if (w_cand >= (W+1)'(N)) begin
                w_cand = w_cand - (W+1)'(N);
            end
            if (req[w_cand[W-1:0]]) begin
                found = 1'b1;
                idx   = w_cand[W-1:0];
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stream_rr_arbiter
// Purpose  : Round-robin burst arbiter sharing one AXI4-Stream datapath among
//            S_COUNT producers, with a single registered output stage.
//            Optional m_axis_tid port enabled by defining STREAM_ARB_TID_EN.
// Revision : 1.0 - initial release
// ============================================================================
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 16
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready
`ifdef STREAM_ARB_TID_EN
    ,
    output logic [$clog2(S_COUNT)-1:0]    m_axis_tid
`endif
);

    localparam int c_IDX_W = idx_w(S_COUNT);
    localparam int c_CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(S_COUNT - 1);
    localparam logic [c_CNT_W-1:0] c_BURST_CNT = c_CNT_W'(BURST_LEN);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [c_IDX_W-1:0]    r_ptr;
    logic [c_IDX_W-1:0]    r_grant_idx;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_m_valid;

    logic                  w_pick_found;
    logic [c_IDX_W-1:0]    w_pick_idx;
    logic                  w_out_ready;
    logic                  w_grant_open;
    logic                  w_accept;
    logic                  w_last_beat;
    logic [DATA_WIDTH-1:0] w_gnt_data;

    rr_pick #(
        .N (S_COUNT),
        .W (c_IDX_W)
    ) u_rr_pick (
        .req   (s_axis_tvalid),
        .ptr   (r_ptr),
        .found (w_pick_found),
        .idx   (w_pick_idx)
    );

    // The output stage can take a beat when empty or draining this cycle.
    assign w_out_ready  = !r_m_valid || m_axis_tready;
    assign w_grant_open = (r_state == ST_GRANT) && !ap_rst && w_out_ready;
    assign w_accept     = w_grant_open && s_axis_tvalid[r_grant_idx];
    assign w_last_beat  = w_accept && (r_cnt == c_CNT_W'(1));
    assign w_gnt_data   = s_axis_tdata[int'(r_grant_idx)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        s_axis_tready = '0;
        if (w_grant_open) begin
            s_axis_tready[r_grant_idx] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (|s_axis_tvalid) w_state_nxt = ST_ARB;
            ST_ARB:   w_state_nxt = w_pick_found ? ST_GRANT : ST_IDLE;
            ST_GRANT: if (w_last_beat) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_grant_idx <= '0;
            r_cnt       <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_ARB && w_pick_found) begin
                r_grant_idx <= w_pick_idx;
                r_cnt       <= c_BURST_CNT;
            end
            if (w_accept) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
            if (w_last_beat) begin
                r_ptr <= (r_grant_idx == c_LAST_IDX) ? '0 : r_grant_idx + c_IDX_W'(1);
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
        end else if (w_accept) begin
            r_m_data  <= w_gnt_data;
            r_m_valid <= 1'b1;
        end else if (m_axis_tready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_axis_tdata  = r_m_data;
    assign m_axis_tvalid = r_m_valid;

`ifdef STREAM_ARB_TID_EN
    logic [c_IDX_W-1:0] r_m_tid;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_m_tid <= '0;
        end else if (w_accept) begin
            r_m_tid <= r_grant_idx;
        end
    end

    assign m_axis_tid = r_m_tid;
`endif

endmodule : stream_rr_arbiter
`default_nettype wire

// File: tb/tb_stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_rr_arbiter
// Purpose  : Self-checking bench for stream_rr_arbiter (S_COUNT=4, BURST_LEN=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_rr_arbiter;

    localparam int S  = 4;
    localparam int DW = 8;
    localparam int BL = 4;

    logic            ap_clk = 1'b0;
    logic            ap_rst = 1'b1;
    logic [S*DW-1:0] s_axis_tdata = '0;
    logic [S-1:0]    s_axis_tvalid = '0;
    logic [S-1:0]    s_axis_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b1;
`ifdef STREAM_ARB_TID_EN
    logic [1:0]      m_axis_tid;
`endif

    stream_rr_arbiter #(
        .S_COUNT    (S),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
`ifdef STREAM_ARB_TID_EN
        ,
        .m_axis_tid    (m_axis_tid)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [3:0] vld;
        logic [3:0] exp_rdy;
        logic       exp_mv;
        logic [7:0] exp_data;
    } vec_t;

    typedef struct {
        int         src;
        logic [7:0] data;
    } sb_t;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] src_next [S];
    logic [3:0] src_on = '0;
    logic [3:0] acc = '0;
    bit         rnd_data = 1'b0;
    bit         bp_mode = 1'b0;
    bit         rdy2_seen = 1'b0;
    int         log_q [$];
    sb_t        sb_q [$];
    vec_t       tab [14];
    int         ord [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        s_axis_tvalid = src_on;
        for (int i = 0; i < S; i++) s_axis_tdata[i*DW +: DW] = src_next[i];
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
        for (int i = 0; i < S; i++) begin
            if (acc[i]) src_next[i] = rnd_data ? 8'($urandom) : src_next[i] + 8'd1;
        end
        drive();
    endtask

    task automatic do_reset();
        ap_rst        = 1'b1;
        src_on        = '0;
        m_axis_tready = 1'b1;
        drive();
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        log_q.delete();
        drive();
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k;
        k = 0;
        drive();
        while (log_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (log_q.size() < n) chk("beat_timeout", log_q.size(), n);
    endtask

    // Input-side acceptance feeds the scoreboard; output transfers drain it.
    always @(negedge ap_clk) begin
        if (ap_rst) begin
            acc = '0;
            sb_q.delete();
        end else begin
            acc = s_axis_tvalid & s_axis_tready;
            if (s_axis_tready[2]) rdy2_seen = 1'b1;
            if (bp_mode && m_axis_tvalid && !m_axis_tready) chk("bp_hold_rdy", s_axis_tready, 0);
            for (int i = 0; i < S; i++) begin
                if (acc[i]) begin
                    sb_q.push_back('{src: i, data: s_axis_tdata[i*DW +: DW]});
                    log_q.push_back(i);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_underflow: got beat %0h expected none", m_axis_tdata);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    chk("sb_data", m_axis_tdata, e.data);
`ifdef STREAM_ARB_TID_EN
                    chk("sb_tid", m_axis_tid, e.src);
`endif
                end
            end
        end
    end

    initial begin
        src_next[0] = 8'h00;
        src_next[1] = 8'h40;
        src_next[2] = 8'h10;
        src_next[3] = 8'hC0;
        ord[0] = 0; ord[1] = 1; ord[2] = 3;

        tab[0]  = '{4'b0100, 4'b0000, 1'b0, 8'h00};
        tab[1]  = '{4'b0100, 4'b0000, 1'b0, 8'h00};
        tab[2]  = '{4'b0100, 4'b0100, 1'b0, 8'h00};
        tab[3]  = '{4'b0100, 4'b0100, 1'b1, 8'h10};
        tab[4]  = '{4'b0100, 4'b0100, 1'b1, 8'h11};
        tab[5]  = '{4'b0100, 4'b0100, 1'b1, 8'h12};
        tab[6]  = '{4'b0100, 4'b0000, 1'b1, 8'h13};
        tab[7]  = '{4'b0100, 4'b0000, 1'b0, 8'h00};
        tab[8]  = '{4'b0100, 4'b0100, 1'b0, 8'h00};
        tab[9]  = '{4'b0100, 4'b0100, 1'b1, 8'h14};
        tab[10] = '{4'b0100, 4'b0100, 1'b1, 8'h15};
        tab[11] = '{4'b0100, 4'b0100, 1'b1, 8'h16};
        tab[12] = '{4'b0000, 4'b0000, 1'b1, 8'h17};
        tab[13] = '{4'b0000, 4'b0000, 1'b0, 8'h00};

        // Reset state, with every input requesting.
        src_on = 4'b1111;
        drive();
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_mvalid", m_axis_tvalid, 0);
        chk("rst_rdy", s_axis_tready, 0);
        chk("rst_mdata", m_axis_tdata, 0);

        // Single requester, cycle-exact table.
        do_reset();
        for (int c = 0; c < 14; c++) begin
            src_on = tab[c].vld;
            drive();
            @(negedge ap_clk);
            chk("tab_rdy", s_axis_tready, tab[c].exp_rdy);
            chk("tab_mvalid", m_axis_tvalid, tab[c].exp_mv);
            if (tab[c].exp_mv) chk("tab_mdata", m_axis_tdata, tab[c].exp_data);
            tick();
        end

        // Rotation among inputs 0, 1 and 3.
        do_reset();
        rdy2_seen = 1'b0;
        src_on    = 4'b1011;
        wait_beats(24, 200);
        src_on = '0;
        for (int j = 0; j < 24 && j < log_q.size(); j++) chk("rot_src", log_q[j], ord[(j/4)%3]);
        chk("rot_no_rdy2", rdy2_seen, 0);

        // Pointer wrap: a burst on 2 leaves ptr at 3, then 3 and 0 alternate.
        do_reset();
        src_on = 4'b0100;
        wait_beats(4, 50);
        src_on = 4'b1001;
        log_q.delete();
        wait_beats(16, 200);
        for (int j = 0; j < 16 && j < log_q.size(); j++) chk("wrap_src", log_q[j], ((j/4)%2 == 0) ? 3 : 0);

        // Mid-burst stall holds the grant.
        do_reset();
        src_on = 4'b0011;
        wait_beats(1, 50);
        chk("stall_first", log_q[0], 0);
        src_on = 4'b0010;
        repeat (5) begin
            drive();
            @(negedge ap_clk);
            chk("stall_rdy", s_axis_tready, 4'b0001);
            tick();
        end
        src_on = 4'b0011;
        wait_beats(5, 50);
        for (int j = 1; j < 4; j++) chk("stall_src", log_q[j], 0);
        chk("stall_next", log_q[4], 1);

        // Reset mid-burst with the output register full.
        do_reset();
        src_on = 4'b0100;
        wait_beats(4, 50);
        src_on = 4'b1100;
        log_q.delete();
        wait_beats(2, 50);
        chk("mrst_pre_src", log_q[0], 3);
        ap_rst        = 1'b1;
        m_axis_tready = 1'b0;
        drive();
        @(negedge ap_clk);
        chk("mrst_full", m_axis_tvalid, 1);
        chk("mrst_rdy_in_rst", s_axis_tready, 0);
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        drive();
        @(negedge ap_clk);
        chk("mrst_mvalid", m_axis_tvalid, 0);
        chk("mrst_rdy", s_axis_tready, 0);
        chk("mrst_mdata", m_axis_tdata, 0);
        m_axis_tready = 1'b1;
        log_q.delete();
        wait_beats(1, 50);
        chk("mrst_regrant", log_q[0], 2);

        // Backpressure with random data and valids, scoreboard-checked.
        do_reset();
        rnd_data = 1'b1;
        bp_mode  = 1'b1;
        for (int k = 0; k < 3000 && log_q.size() < 64; k++) begin
            m_axis_tready = (k < 16) ? ((k % 4 == 0) || (k % 4 == 3)) : 1'($urandom_range(0, 1));
            src_on[1]     = ($urandom_range(0, 3) != 0);
            src_on[3]     = ($urandom_range(0, 3) != 0);
            drive();
            tick();
        end
        chk("bp_beats", log_q.size() >= 64, 1);
        src_on        = '0;
        m_axis_tready = 1'b1;
        drive();
        repeat (4) tick();
        bp_mode = 1'b0;
        chk("sb_drain", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_stream_rr_arbiter
`default_nettype wire
